ysyx_25040118_ifu: RTL and testbench
====================================

// Module: ysyx_25040118_ifu
// PURPOSE
//  Instruction fetch stage. Holds the PC and issues one fetch request at a time on an SRAM-style memory port.
//  Returns {pc, inst, fault} to the decode stage over a valid/ready handshake.
//  Accepts a redirect (branch/jump/trap target) from execute/writeback at any time.
//  At most one request outstanding; stale responses after a redirect are dropped.
// PARAMETERS
//  XLEN      32            address/data width
//  RESET_PC  32'h8000_0000 PC loaded on reset
//  INST_STEP 4             PC increment per consumed instruction (bytes)
// PORTS
//  clk            in  1     single clock, all flops on posedge
//  rst_n          in  1     asynchronous, active-low reset
//  mem_req_valid  out 1     fetch request valid
//  mem_req_ready  in  1     memory accepts request
//  mem_req_addr   out XLEN  fetch address (= pc)
//  mem_resp_valid in  1     response valid (exactly one per accepted request)
//  mem_resp_data  in  XLEN  instruction word
//  mem_resp_err   in  1     access fault on this response
//  out_valid      out 1     fetched instruction valid to decode
//  out_ready      in  1     decode accepts
//  out_pc         out XLEN  PC of instruction
//  out_inst       out XLEN  instruction word (0 when out_fault=1)
//  out_fault      out 1     fetch access fault
//  redirect_valid in  1     load new PC
//  redirect_pc    in  XLEN  target PC
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=REQ, drop=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0.
//   mem_req_valid is 0 while rst_n low and 1 from the first cycle after release.
//  States: REQ, WAIT, HOLD. mem_req_valid=(state==REQ); mem_req_addr=pc; out_valid=(state==HOLD); all registered decodes.
//  REQ:  req handshake -> WAIT. No handshake -> stay.
//  WAIT: resp_valid & !drop -> capture out_pc=pc, out_inst=err?0:data, out_fault=err; -> HOLD.
//        resp_valid & drop  -> discard, drop<=0, -> REQ.
//  HOLD: out_valid & out_ready -> pc<=pc+INST_STEP (mod 2^XLEN, wraps silently), -> REQ.
//        out_pc/out_inst/out_fault stable while out_valid & !out_ready.
//  Latency: zero-wait memory (ready=1, resp next cycle) plus ready decode gives REQ, WAIT, HOLD = 3 cycles/inst.
//   out_valid rises 2 cycles after the req handshake cycle.
//  Redirect takes priority over every other pc update and is checked each cycle:
//   REQ, no handshake same cycle: pc<=redirect_pc, stay REQ. The address may change while valid; memory samples only on handshake.
//   REQ, handshake same cycle: pc<=redirect_pc, drop<=1, -> WAIT.
//   WAIT, no resp: pc<=redirect_pc, drop<=1, stay WAIT.
//   WAIT, resp same cycle: response discarded regardless of drop, drop<=0, pc<=redirect_pc, -> REQ.
//   HOLD: pc<=redirect_pc, -> REQ. If out_ready is also high, the transfer still completes (decode owns the flush)
//    and pc does NOT also increment.
//   Back-to-back redirects: last one wins; drop stays 1 until the single outstanding response returns.
//  mem_resp_valid outside WAIT is a protocol error: ignored, no state change.
//  Fault responses are passed through, not retried. pc advances on consume like any other instruction.
//  Reset mid-transaction: all state cleared immediately. Memory must discard in-flight responses across reset.
// STRUCTURE
//  Shared config header: XLEN, RESET_PC, INST_STEP defaults; IFU state encodings (REQ=2'd0, WAIT=2'd1, HOLD=2'd2).
//  Single module; all flops inline with async active-low reset. No sub-module needed.
//  Optional helper ysyx_25040118_ifu_pcnext (combinational next-pc select) if the pc update grows.
// TESTING
//  1 Reset release, mem ready=1, 1-cycle resp, out_ready=1, data=inst_i -> out_pc 0x80000000, 0x80000004, 0x80000008 at 3-cycle spacing.
//  2 out_ready=0 for 5 cycles in HOLD -> out_* stable, mem_req_valid=0, pc unchanged; ready=1 -> next req addr pc+4.
//  3 Redirect to 0x80001000 in WAIT, resp 2 cycles later -> resp dropped, out_valid stays 0, next req addr 0x80001000.
//  4 Redirect same cycle as resp_valid -> no out_valid; next req 0x80001000, drop=0.
//  5 resp_err=1, data=0xdeadbeef -> out_fault=1, out_inst=0, out_pc correct; consume -> pc+4.
//  6 pc=0xfffffffc consumed -> next req addr 0x00000000. Assert rst_n low mid-WAIT -> outputs to reset values same cycle.

Source files
------------

// File: rtl/ysyx_25040118_ifu_pkg.sv
// Shared configuration for the instruction fetch unit.
//   IFU_XLEN       default address/data width
//   IFU_RESET_PC   PC loaded on reset
//   IFU_INST_STEP  bytes the PC advances per consumed instruction
//   ifu_state_e    fetch FSM encodings (REQ=0, WAIT=1, HOLD=2)
package ysyx_25040118_ifu_pkg;

  localparam int          IFU_XLEN      = 32;
  localparam logic [31:0] IFU_RESET_PC  = 32'h8000_0000;
  localparam int          IFU_INST_STEP = 4;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25040118_ifu_pcnext.sv
// Next-PC select for the fetch unit.
//   pc             current PC
//   consume        decode accepted the held instruction this cycle
//   redirect_valid / redirect_pc  new target from execute/writeback
//   pc_next        PC for the next cycle
// A redirect always wins, so a consume in the same cycle does not also add
// the step. The increment wraps modulo 2^XLEN.
module ysyx_25040118_ifu_pcnext
  import ysyx_25040118_ifu_pkg::*;
#(
  parameter int XLEN      = IFU_XLEN,
  parameter int INST_STEP = IFU_INST_STEP
) (
  input  logic [XLEN-1:0] pc,
  input  logic            consume,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_next
);

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (consume) begin
      pc_next = pc + XLEN'(INST_STEP);
    end
  end

endmodule

// File: rtl/ysyx_25040118_ifu.sv
// Instruction fetch stage. Holds the PC, keeps at most one request in flight
// on an SRAM-style memory port and hands {pc, inst, fault} to decode over a
// valid/ready handshake. Redirects are accepted in any cycle; a response whose
// request was issued before the redirect is dropped.
//   clk, rst_n                      clock, async active-low reset
//   mem_req_valid/ready/addr        fetch request (addr = pc)
//   mem_resp_valid/data/err         fetch response, one per accepted request
//   out_valid/ready, out_pc/inst/fault  instruction to decode
//   redirect_valid, redirect_pc     PC override
module ysyx_25040118_ifu
  import ysyx_25040118_ifu_pkg::*;
#(
  parameter int              XLEN      = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(IFU_RESET_PC),
  parameter int              INST_STEP = IFU_INST_STEP
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            mem_resp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_inst_q, out_inst_d;
  logic            out_fault_q, out_fault_d;

  logic req_hs;
  logic consume;

  assign req_hs  = mem_req_valid_q & mem_req_ready;
  assign consume = out_valid_q & out_ready;

  ysyx_25040118_ifu_pcnext #(
    .XLEN      (XLEN),
    .INST_STEP (INST_STEP)
  ) u_pcnext (
    .pc             (pc_q),
    .consume        (consume),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_next        (pc_d)
  );

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_fault_d = out_fault_q;

    case (state_q)
      IFU_REQ: begin
        if (req_hs) begin
          state_d = IFU_WAIT;
          // The request just issued targets the old pc.
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      IFU_WAIT: begin
        if (mem_resp_valid) begin
          // A redirect arriving with the response makes it stale too.
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = IFU_REQ;
          end else begin
            out_pc_d    = pc_q;
            out_inst_d  = mem_resp_err ? '0 : mem_resp_data;
            out_fault_d = mem_resp_err;
            state_d     = IFU_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      IFU_HOLD: begin
        if (redirect_valid || consume) state_d = IFU_REQ;
      end
      default: state_d = IFU_REQ;
    endcase

    // Handshake outputs are decoded from the next state so they come straight
    // from flops.
    mem_req_valid_d = (state_d == IFU_REQ);
    out_valid_d     = (state_d == IFU_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IFU_REQ;
      pc_q            <= RESET_PC;
      drop_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_pc_q        <= '0;
      out_inst_q      <= '0;
      out_fault_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      drop_q          <= drop_d;
      mem_req_valid_q <= mem_req_valid_d;
      out_valid_q     <= out_valid_d;
      out_pc_q        <= out_pc_d;
      out_inst_q      <= out_inst_d;
      out_fault_q     <= out_fault_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = pc_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_pc_q;
  assign out_inst      = out_inst_q;
  assign out_fault     = out_fault_q;

endmodule

// File: tb/tb_ysyx_25040118_ifu.sv
// Directed bench for the fetch unit. A small memory stand-in answers each
// accepted request after resp_lat cycles with data = addr + 0x13, or with an
// access fault carrying 0xdeadbeef when fault_mode is set.
module tb_ysyx_25040118_ifu;

  logic        clk;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int          total;
  int          bad;
  int          cycle;
  int          resp_lat;
  int          pend_cnt;
  logic [31:0] pend_addr;
  logic        fault_mode;
  int          c0;

  ysyx_25040118_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_fault      (out_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: latch a handshake seen before the edge, then drive the
  // response (if due) just after it.
  task automatic tick();
    if (mem_req_valid && mem_req_ready) begin
      pend_addr = mem_req_addr;
      pend_cnt  = resp_lat;
    end
    @(posedge clk);
    #1;
    cycle++;
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
    mem_resp_data  = '0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_err   = fault_mode;
        mem_resp_data  = fault_mode ? 32'hdead_beef : pend_addr + 32'h13;
      end
    end
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    total = 0; bad = 0; cycle = 0;
    resp_lat = 1; pend_cnt = 0; pend_addr = '0; fault_mode = 1'b0;
    rst_n = 1'b0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0; mem_resp_err = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Reset state
    #12;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_fault", 32'(out_fault), 32'd0);
    chk("rst_addr", mem_req_addr, 32'h8000_0000);
    rst_n = 1'b1;
    tick();
    chk("rel_req_valid", 32'(mem_req_valid), 32'd1);

    // 1: streaming fetch, 3 cycles per instruction
    wait_out("t1a");
    c0 = cycle;
    chk("t1a_pc", out_pc, 32'h8000_0000);
    chk("t1a_inst", out_inst, 32'h8000_0013);
    chk("t1a_fault", 32'(out_fault), 32'd0);
    tick();
    wait_out("t1b");
    chk("t1b_pc", out_pc, 32'h8000_0004);
    chk("t1b_inst", out_inst, 32'h8000_0017);
    chk("t1b_gap", 32'(cycle - c0), 32'd3);
    c0 = cycle;
    tick();
    wait_out("t1c");
    chk("t1c_pc", out_pc, 32'h8000_0008);
    chk("t1c_gap", 32'(cycle - c0), 32'd3);
    tick();

    // 2: decode stalls 5 cycles in HOLD
    out_ready = 1'b0;
    wait_out("t2");
    chk("t2_pc", out_pc, 32'h8000_000c);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 32'(out_valid), 32'd1);
      chk("t2_hold_pc", out_pc, 32'h8000_000c);
      chk("t2_hold_inst", out_inst, 32'h8000_001f);
      chk("t2_hold_req", 32'(mem_req_valid), 32'd0);
      chk("t2_hold_addr", mem_req_addr, 32'h8000_000c);
    end
    out_ready = 1'b1;
    tick();
    chk("t2_next_req", 32'(mem_req_valid), 32'd1);
    chk("t2_next_addr", mem_req_addr, 32'h8000_0010);

    // 3: redirect while waiting, stale response two cycles later
    resp_lat = 2;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    chk("t3_wait_out_valid", 32'(out_valid), 32'd0);
    chk("t3_wait_req", 32'(mem_req_valid), 32'd0);
    chk("t3_stale_resp", 32'(mem_resp_valid), 32'd1);
    tick();
    chk("t3_out_valid", 32'(out_valid), 32'd0);
    chk("t3_req", 32'(mem_req_valid), 32'd1);
    chk("t3_addr", mem_req_addr, 32'h8000_1000);
    resp_lat = 1;
    wait_out("t3");
    chk("t3_pc", out_pc, 32'h8000_1000);
    chk("t3_inst", out_inst, 32'h8000_1013);
    tick();

    // 4: redirect in the same cycle as the response
    chk("t4_start_addr", mem_req_addr, 32'h8000_1004);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_req", 32'(mem_req_valid), 32'd1);
    chk("t4_addr", mem_req_addr, 32'h8000_1000);
    wait_out("t4");
    chk("t4_pc", out_pc, 32'h8000_1000);
    tick();

    // 5: access fault passes through
    fault_mode = 1'b1;
    wait_out("t5");
    fault_mode = 1'b0;
    chk("t5_fault", 32'(out_fault), 32'd1);
    chk("t5_inst", out_inst, 32'h0);
    chk("t5_pc", out_pc, 32'h8000_1004);
    tick();
    chk("t5_next_addr", mem_req_addr, 32'h8000_1008);

    // Redirect in HOLD with decode ready: no extra increment
    wait_out("thr");
    redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
    tick();
    redirect_valid = 1'b0;
    chk("thr_out_valid", 32'(out_valid), 32'd0);
    chk("thr_addr", mem_req_addr, 32'hffff_fffc);

    // 6: pc wrap, then reset mid-WAIT
    wait_out("t6");
    chk("t6_pc", out_pc, 32'hffff_fffc);
    chk("t6_inst", out_inst, 32'h0000_000f);
    tick();
    chk("t6_wrap_addr", mem_req_addr, 32'h0000_0000);
    tick();
    chk("t6_in_wait", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b0;
    pend_cnt = 0;
    mem_resp_valid = 1'b0;
    #1;
    chk("t6_rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_out_pc", out_pc, 32'h0);
    chk("t6_rst_out_inst", out_inst, 32'h0);
    chk("t6_rst_addr", mem_req_addr, 32'h8000_0000);
    #1;
    rst_n = 1'b1;
    tick();
    wait_out("t6r");
    chk("t6_restart_pc", out_pc, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
